// File: rtl/mem_access_unit_if.sv
// Request/response and word-memory signals between pipeline, memory access unit and memory.
// The unit uses the slave view; the surrounding pipeline/memory environment uses the master view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [63:0]       resp_data;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_data,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_data,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV64 load/store unit in front of a 64-bit word memory: size/sign decode, alignment checks,
// lane extraction for loads and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int ADDR_W = 64
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [63:0]       resp_data_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [63:0]       mem_wdata_q;

  // Decode of the incoming request, only consumed while IDLE.
  logic req_illegal;
  logic req_misal;
  logic req_err;
  logic req_sd;

  assign req_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
  always_comb begin
    req_misal = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   req_misal = bus.req_addr[0];
      2'b10:   req_misal = |bus.req_addr[1:0];
      2'b11:   req_misal = |bus.req_addr[2:0];
      default: req_misal = 1'b0;
    endcase
  end
  assign req_err = req_illegal | req_misal;
  assign req_sd  = bus.req_we & (bus.req_funct3[1:0] == 2'b11);

  logic [2:0]  off;
  logic [63:0] lane;
  logic [63:0] load_val_d;
  logic [63:0] merged_d;
  logic [63:0] wdata_sh;
  logic [7:0]  byte_en;
  logic [7:0]  byte_en_sh;

  assign off  = addr_q[2:0];
  assign lane = bus.mem_rdata >> {off, 3'b000};

  always_comb begin
    load_val_d = '0;
    case (funct3_q)
      3'b000:  load_val_d = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_val_d = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_val_d = {{32{lane[31]}}, lane[31:0]};
      3'b011:  load_val_d = lane;
      3'b100:  load_val_d = {56'd0, lane[7:0]};
      3'b101:  load_val_d = {48'd0, lane[15:0]};
      3'b110:  load_val_d = {32'd0, lane[31:0]};
      default: load_val_d = '0;
    endcase
  end

  always_comb begin
    byte_en = 8'hFF;
    case (funct3_q[1:0])
      2'b00:   byte_en = 8'h01;
      2'b01:   byte_en = 8'h03;
      2'b10:   byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end
  assign byte_en_sh = byte_en << off;
  assign wdata_sh   = wdata_q << {off, 3'b000};

  // Sub-word store merge: addressed lanes from the store data, the rest from the old word.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign merged_d[gi*8 +: 8] = byte_en_sh[gi] ? wdata_sh[gi*8 +: 8] : bus.mem_rdata[gi*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q        <= bus.req_we;
          funct3_q    <= bus.req_funct3;
          addr_q      <= bus.req_addr;
          wdata_q     <= bus.req_wdata;
          req_ready_q <= 1'b0;
          if (req_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (req_sd) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= bus.req_wdata;
          end else begin
            state_q    <= RD;
            mem_read_q <= 1'b1;
          end
        end
        RD: begin
          mem_read_q <= 1'b0;
          if (we_q) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merged_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_val_d;
          end
        end
        WR: begin
          state_q      <= RESP;
          mem_write_q  <= 1'b0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed literal cases plus random traffic checked every cycle
// against a transaction-level model with its own copy of memory.
module tb_mem_access_unit;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mem_access_unit_if #(.ADDR_W(64)) bus ();
  mem_access_unit #(.ADDR_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] init_word(int i);
    if (i == 4) return 64'hFFFF_FFFF_FFFF_FFFE;
    if (i == 5) return 64'h0000_0000_0000_000A;
    return {32'hC0DE_0000 | 32'(i), 32'h8765_4321 ^ (32'(i) * 32'h0101_0101)};
  endfunction

  // Word memory covering 0x100..0x17F, combinational read, write on posedge.
  logic [63:0] mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr[6:3]];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_err(logic we, logic [2:0] f3, logic [63:0] addr);
    logic illegal = we ? (f3 >= 3'd4) : (f3 == 3'd7);
    return illegal || ((addr % 64'(nbytes(f3))) != 0);
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] w, logic [2:0] f3, logic [2:0] off);
    int          nb   = nbytes(f3);
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v    = (w >> (8 * int'(off))) & mask;
    if (f3 < 3'd4 && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] m_store(logic [63:0] old, logic [2:0] f3, logic [2:0] off,
                                          logic [63:0] d);
    int          nb   = nbytes(f3);
    logic [63:0] mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * int'(off));
    return (old & ~mask) | ((d << (8 * int'(off))) & mask);
  endfunction

  logic [63:0] ref_mem [16];

  // Transaction schedule: kind 0 error, 1 load, 2 sd, 3 sub-word store; phase counts cycles since accept.
  initial begin : compare
    int          phase = 0;
    int          lat   = 0;
    int          kind  = 0;
    int          idx   = 0;
    logic [63:0] e_addr = '0;
    logic [63:0] e_val  = '0;
    logic        e_rdy, e_rd, e_wr, e_rv, e_er;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_outs", {bus.mem_read, bus.mem_write, bus.resp_valid, bus.resp_err}, 0);
        chk("rst_data", bus.resp_data, 0);
        continue;
      end
      e_rdy = (phase == 0);
      e_rd  = (phase == 1) && (kind == 1 || kind == 3);
      e_wr  = (kind == 2 && phase == 1) || (kind == 3 && phase == 2);
      e_rv  = (phase != 0) && (phase == lat);
      e_er  = e_rv && (kind == 0);
      chk("req_ready", bus.req_ready, e_rdy);
      chk("mem_read", bus.mem_read, e_rd);
      chk("mem_write", bus.mem_write, e_wr);
      chk("resp_valid", bus.resp_valid, e_rv);
      chk("resp_err", bus.resp_err, e_er);
      if (e_rd || e_wr) chk("mem_addr", bus.mem_addr, e_addr & ~64'd7);
      if (e_wr) begin
        chk("mem_wdata", bus.mem_wdata, e_val);
        ref_mem[idx] = e_val;
      end
      if (e_rv) begin
        chk("resp_data", bus.resp_data, (kind == 1) ? e_val : 64'd0);
        $display("[TB] resp kind=%0d addr=%h data=%h err=%0b", kind, e_addr, bus.resp_data,
                 bus.resp_err);
      end
      if (phase != 0) begin
        phase = (phase == lat) ? 0 : phase + 1;
      end else if (bus.req_valid) begin
        e_addr = bus.req_addr;
        idx    = int'(e_addr[6:3]);
        phase  = 1;
        if (m_err(bus.req_we, bus.req_funct3, e_addr)) begin
          kind = 0; lat = 1;
        end else if (!bus.req_we) begin
          kind = 1; lat = 2;
          e_val = m_load(ref_mem[idx], bus.req_funct3, e_addr[2:0]);
        end else begin
          kind  = (bus.req_funct3 == 3'd3) ? 2 : 3;
          lat   = (kind == 2) ? 2 : 3;
          e_val = m_store(ref_mem[idx], bus.req_funct3, e_addr[2:0], bus.req_wdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] d);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic err, output logic [63:0] data,
                           output logic saw_rd, output logic saw_wr, output logic [63:0] wd);
    lat = 0; err = 1'b0; data = '0; saw_rd = 1'b0; saw_wr = 1'b0; wd = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_read) saw_rd = 1'b1;
      if (bus.mem_write) begin saw_wr = 1'b1; wd = bus.mem_wdata; end
      if (bus.resp_valid) begin
        lat = n; err = bus.resp_err; data = bus.resp_data;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin : stim
    int          lat;
    logic        err, srd, swr;
    logic [63:0] data, wd;
    logic [2:0]  f3;
    logic [63:0] a;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    chk("model_lw", m_load(64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 3'd4), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_lbu", m_load(64'hFFFF_FFFF_FFFF_FFFE, 3'b100, 3'd0), 64'hFE);
    chk("model_sb", m_store(64'hA, 3'b000, 3'd3, 64'h55), 64'h0000_0000_5500_000A);
    chk("model_sd", m_store(64'hA, 3'b011, 3'd0, 64'h8), 64'h8);
    chk("model_err", {m_err(1'b0, 3'b001, 64'h121), m_err(1'b0, 3'b111, 64'h120),
                      m_err(1'b1, 3'b100, 64'h120), m_err(1'b0, 3'b010, 64'h124)}, 4'b1110);

    idle(3); #3 rst = 1'b0;
    idle(2);

    do_req(1'b0, 3'b010, 64'h124, 64'h0);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] lw 0x124 lat=%0d data=%h", lat, data);
    chk("lw_lat", 64'(lat), 2);
    chk("lw_data", data, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(2);

    do_req(1'b0, 3'b100, 64'h120, 64'h0);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] lbu 0x120 lat=%0d data=%h", lat, data);
    chk("lbu_data", data, 64'hFE);
    idle(2);

    do_req(1'b1, 3'b000, 64'h12B, 64'h55);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] sb 0x12B lat=%0d wdata=%h", lat, wd);
    chk("sb_lat", 64'(lat), 3);
    chk("sb_rmw", {srd, swr, err}, 3'b110);
    chk("sb_wdata", wd, 64'h0000_0000_5500_000A);
    idle(2);

    do_req(1'b1, 3'b011, 64'h130, 64'h8);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] sd 0x130 lat=%0d wdata=%h", lat, wd);
    chk("sd_lat", 64'(lat), 2);
    chk("sd_rw", {srd, swr}, 2'b01);
    chk("sd_wdata", wd, 64'h8);
    idle(2);

    do_req(1'b0, 3'b001, 64'h121, 64'h0);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] lh 0x121 lat=%0d err=%0b", lat, err);
    chk("lh_mis", {64'(lat), 1'b0, err, srd, swr}, {64'd1, 1'b0, 3'b100});
    chk("lh_data", data, 0);
    idle(2);

    do_req(1'b0, 3'b111, 64'h120, 64'h0);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] load f3=111 lat=%0d err=%0b", lat, err);
    chk("ill_err", {64'(lat), 1'b0, err, srd, swr}, {64'd1, 1'b0, 3'b100});
    chk("ill_data", data, 0);
    idle(2);

    // Reset pulse in the RD cycle of sw 0x138.
    do_req(1'b1, 3'b010, 64'h138, 64'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    $display("[TB] sw 0x138 aborted by reset");
    chk("arst_rd", bus.mem_read, 0);
    chk("arst_ready", bus.req_ready, 1);
    @(posedge clk); #3 rst = 1'b0;
    idle(6);
    chk("arst_nowrite", mem[7], init_word(7));
    do_req(1'b1, 3'b010, 64'h138, 64'h1234_5678);
    wait_resp(lat, err, data, srd, swr, wd);
    $display("[TB] sw 0x138 after reset lat=%0d wdata=%h", lat, wd);
    chk("sw_lat", 64'(lat), 3);
    chk("sw_wdata", wd, {init_word(7)[63:32], 32'h1234_5678});
    idle(2);

    // Random traffic; odd segments hold req_valid high with slowly changing fields.
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        if (seg % 2 == 1) begin
          bus.req_valid = 1'b1;
          if (c % 40 != 0) continue;
        end else begin
          bus.req_valid = ($urandom_range(0, 3) != 0);
        end
        f3 = 3'($urandom_range(0, 7));
        a  = 64'h100 + 64'($urandom_range(0, 127));
        if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << f3[1:0]) - 1);
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = {$urandom, $urandom};
      end
    end
    bus.req_valid = 1'b0;
    idle(8);
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: width of req_addr and mem_addr (at least 8).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: pipeline presents a memory request.
REQ-005 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV64 size/sign code.
REQ-008 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-009 SHALL have port req_wdata, input, 64: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_err, output, 1: qualifies resp_valid; request was misaligned or illegal.
REQ-012 SHALL have port resp_data, output, 64: load result; 0 for stores and errors.
REQ-013 SHALL have port mem_read, output, 1: word-memory read enable.
REQ-014 SHALL have port mem_write, output, 1: word-memory write enable, sampled at memory posedge.
REQ-015 SHALL have port mem_addr, output, ADDR_W: {addr_q[ADDR_W-1:3], 3'b000}.
REQ-016 SHALL have port mem_wdata, output, 64: full 64-bit word to write.
REQ-017 SHALL have port mem_rdata, input, 64: combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 SHALL be an FSM with states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL, on req_valid & req_ready, register we/funct3/addr/wdata into *_q, and then ignore the request inputs until IDLE is re-entered.
REQ-020 SHALL decode loads as: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 is illegal.
REQ-021 SHALL decode stores as: 000 sb, 001 sh, 010 sw, 011 sd; 1xx is illegal.
REQ-022 SHALL treat as misaligned: h with addr[0]!=0, w with addr[1:0]!=0, d with addr[2:0]!=0.
REQ-023 SHALL, for an illegal or misaligned request, go IDLE->RESP with resp_err=1 and resp_data=0, never asserting mem_read or mem_write.
REQ-024 SHALL sequence a legal load IDLE->RD->RESP: mem_read=1 in RD, and the extracted result is registered at the end of RD.
REQ-025 SHALL extract the load lane at byte offset addr_q[2:0]; signed ops sign-extend and unsigned ops zero-extend to 64 bits.
REQ-026 SHALL sequence sd IDLE->WR->RESP, with mem_write=1 and mem_wdata=wdata_q in WR.
REQ-027 SHALL perform sb/sh/sw as read-modify-write IDLE->RD->WR->RESP: capture mem_rdata in RD; in WR, replace only the addressed byte lanes with wdata_q low bits.
REQ-028 SHALL assert resp_valid for exactly the single RESP cycle, then return to IDLE; there is no response backpressure.
REQ-029 SHALL have accept-to-resp_valid latency of 1 cycle (error), 2 (load, sd) or 3 (sub-word store); back-to-back throughput is one request per latency+1 cycles.
REQ-030 SHALL drive mem_read, mem_write, resp_valid and resp_err to 0 in every state other than those stated above.
REQ-031 SHALL keep mem_read and mem_write mutually exclusive in all cycles.

Reset
REQ-032 SHALL, while rst=1 (asynchronously, including mid-transaction), force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_read=0, mem_write=0, and clear all *_q registers.
REQ-033 SHALL emit no resp_valid for a transaction aborted by reset; the memory word is unmodified if reset asserts before the WR-cycle posedge.

Verification
REQ-034 SHALL pass: mem word @0x120 = 0xFFFF_FFFF_FFFF_FFFE; lw 0x124 -> RD at T+1, resp_valid at T+2, resp_data=0xFFFF_FFFF_FFFF_FFFF; lbu 0x120 -> 0x0000_0000_0000_00FE.
REQ-035 SHALL pass: word @0x128 = 0x0000_0000_0000_000A; sb 0x12B data 0x55 -> RD, WR with mem_wdata=0x0000_0000_5500_000A, resp_valid at T+3, resp_err=0.
REQ-036 SHALL pass: sd 0x130 data 0x8 -> a single WR cycle with mem_wdata=0x8, no mem_read, resp_valid at T+2.
REQ-037 SHALL pass: lh 0x121 and load funct3=111 -> resp_valid at T+1 with resp_err=1 and resp_data=0; mem_read and mem_write stay 0.
REQ-038 SHALL pass: rst pulsed during the RD cycle of sw -> outputs reset immediately, no mem_write, no resp_valid; the next request completes normally.
REQ-039 SHALL pass: req_valid held high continuously -> req_ready=0 outside IDLE, each request is accepted exactly once, and mem_read and mem_write never overlap.
